fetch_inst_buffer: RTL

Instruction buffer between the fetch stage-2 output (four instruction packets plus a valid mask) and decode. It compacts valid slots in program order into a circular FIFO and presents up to four oldest entries per cycle to decode. It decouples fetch from decode stalls and raises back-pressure into fetch when it cannot absorb a full bundle.

---
 rtl/fetch_inst_buffer.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: compacting circular instruction buffer between fetch and decode; define FETCH_IB_BYPASS_EN for 0-cycle bypass when empty
module fetch_inst_buffer #(
  parameter int FETCH_WIDTH = 4,
  parameter int PACKET_W    = 133,
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fs2Ready_i,
  input  logic [FETCH_WIDTH-1:0]          instValid_i,
  input  logic [FETCH_WIDTH*PACKET_W-1:0] instBundle_i,
  input  logic                            decodeStall_i,
  input  logic                            flush_i,
  input  logic                            recoverFlag_i,
  output logic [FETCH_WIDTH-1:0]          rdValid_o,
  output logic [FETCH_WIDTH*PACKET_W-1:0] rdBundle_o,
  output logic                            ibFull_o,
  output logic                            ibEmpty_o,
  output logic [PTR_W:0]                  ibCount_o
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] FW_C    = (PTR_W+1)'(FETCH_WIDTH);
  logic [PACKET_W-1:0]    storage [DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [PTR_W:0]         count, n_in, n_avail, n_out, n_wr, n_show;
  logic [FETCH_WIDTH-1:0] v;
  logic [PTR_W-1:0]       pos [FETCH_WIDTH];
  logic [PACKET_W-1:0]    pkt [FETCH_WIDTH];
  logic                   kill, enq, deq, wr;
  assign kill      = flush_i | recoverFlag_i;
  assign ibCount_o = count;
  assign ibEmpty_o = count == '0;
  assign ibFull_o  = (DEPTH_C - count) < FW_C;
  assign enq       = fs2Ready_i & ~ibFull_o & ~kill;
  assign deq       = ~decodeStall_i & ~kill;
  assign n_avail   = count > FW_C ? FW_C : count;
  assign n_out     = deq ? n_avail : '0;
`ifdef FETCH_IB_BYPASS_EN
  logic byp;
  assign byp = enq & ibEmpty_o;
  assign wr  = enq & ~(byp & deq);
`else
  assign wr  = enq;
`endif
  assign n_wr = wr ? n_in : '0;
  // Unpack slots (mask bit order is reversed vs. slot index) and compute compacted positions
  always_comb begin
    n_in = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      v[i]   = instValid_i[FETCH_WIDTH-1-i];
      pkt[i] = instBundle_i[i*PACKET_W +: PACKET_W];
      pos[i] = n_in[PTR_W-1:0];
      n_in   = n_in + (PTR_W+1)'(v[i]);
    end
  end
  // Present the oldest entries, or the compacted incoming bundle when bypassing
  always_comb begin
    n_show = n_avail;
    for (int k = 0; k < FETCH_WIDTH; k++)
      rdBundle_o[k*PACKET_W +: PACKET_W] = storage[head + PTR_W'(k)];
`ifdef FETCH_IB_BYPASS_EN
    if (byp) begin
      n_show     = n_in;
      rdBundle_o = '0;
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (v[i]) rdBundle_o[int'(pos[i])*PACKET_W +: PACKET_W] = pkt[i];
    end
`endif
    for (int k = 0; k < FETCH_WIDTH; k++)
      rdValid_o[k] = n_show > (PTR_W+1)'(k);
  end
  // Pointer and occupancy state; reset and flush/recover all empty the buffer
  always_ff @(posedge clk) begin
    if (reset | kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out[PTR_W-1:0];
      tail  <= tail + n_wr[PTR_W-1:0];
      count <= count + n_wr - n_out;
    end
  end
  // Write valid slots at consecutive positions from the tail
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (wr && v[i]) storage[tail + pos[i]] <= pkt[i];
  end
endmodule
